rr_arbiter_tmo: RTL and testbench
=================================

Name: rr_arbiter_tmo

Overview:
- N-way round-robin arbiter with a per-grant hold-time watchdog for a single shared resource.
- Each requester raises req, receives a one-hot registered grant, and releases it with a one-cycle eot.
- If the owner never sends eot, the watchdog forcibly revokes the grant after a programmable number of cycles and reports the offender.
- A timed-out requester is skipped for one arbitration round.
- Sits between the requesting agents and the shared resource, replacing a fixed 4-way handshake arbiter.

Parameters:
- N, 4, number of requesters (2..16).
- TMO_W, 8, width of the timeout limit and hold counter.
- IDW, $clog2(N), width of owner/timeout index outputs.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N  per-requester request level.
- eot  in  N  per-requester end-of-transfer pulse; only the owner's bit is honoured.
- tmo_limit  in  TMO_W  maximum grant hold in cycles; 0 disables the watchdog; sampled when a grant is issued.
- gnt  out  N  one-hot registered grant; all-zero when no owner.
- gnt_id  out  IDW  index of current owner; valid while busy.
- busy  out  1  high while any gnt bit is high.
- tmo_pulse  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- tmo_id  out  IDW  index of the revoked requester; holds its value until the next tmo_pulse.

Behaviour:
- Reset (rst high at a clock edge) forces the following, and aborts any grant in progress:
  - outputs: gnt=0, gnt_id=0, busy=0, tmo_pulse=0, tmo_id=0;
  - internal: state=IDLE, last=N-1, hold_cnt=0, penalty mask=0, latched limit=0.
- States are IDLE and OWN only.
- IDLE:
  - Eligible set is req & ~penalty.
  - If the eligible set is non-empty, select the first set bit scanning last+1, last+2, ... with wrap modulo N.
  - On that edge: gnt=onehot(sel), gnt_id=sel, last=sel, hold_cnt=0, limit latched, state→OWN.
  - Grant is therefore visible exactly 1 cycle after req is seen in IDLE.
  - If the eligible set is empty but penalty≠0, clear penalty and stay in IDLE; arbitration resumes next cycle.
  - Penalty is otherwise cleared whenever a grant is issued.
- OWN:
  - hold_cnt increments each cycle the grant is visible, saturating at all-ones.
  - Release by eot: if eot[gnt_id] is high, next edge sets gnt=0, state→IDLE.
  - Release by timeout: if the latched limit≠0, hold_cnt==limit-1 and eot[gnt_id] is low, then on the next edge:
    - gnt=0, state→IDLE;
    - tmo_pulse=1 for that one cycle, tmo_id=gnt_id;
    - penalty[gnt_id]=1.
  - The grant is therefore visible exactly limit cycles.
  - Simultaneous eot and timeout: eot wins; no tmo_pulse, no penalty.
  - req is not monitored during OWN; deasserting req does not release the grant.
  - eot bits of non-owners are ignored in every state. eot in IDLE is ignored.
- Handoff: every release forces at least one all-zero gnt cycle (the IDLE cycle). Back-to-back owners are therefore separated by exactly 1 idle cycle.
- Changes to tmo_limit during OWN have no effect until the next grant.
- Invariants: gnt is one-hot or zero at all times; busy == |gnt.
- Fairness: with all N requesting continuously and eot after k cycles, each requester is granted once every N×(k+1) cycles.

Test Plan:
- Reset then req=4'b1111 held, each owner pulses eot on its 2nd grant cycle → grant order 0,1,2,3,0 with one gnt=0 cycle between owners; gnt_id tracks it.
- Only req[2]=1 after reset → gnt=4'b0100 one cycle later. Then eot[2], with req[2] still high → gnt=0 for 1 cycle, then 4'b0100 again.
- tmo_limit=3, req[1] held, no eot → gnt[1] high exactly 3 cycles. On the drop cycle tmo_pulse=1 and tmo_id=1. With req[3] also pending, next grant goes to 3. With only req[1] pending: one IDLE cycle clearing the penalty, then gnt[1] reasserts.
- tmo_limit=3, eot[owner] asserted on the 3rd grant cycle → normal release, tmo_pulse stays 0.
- tmo_limit=0, owner holds 300 cycles → no timeout. hold_cnt saturates at 255 and the grant is held until eot.
- rst asserted for 1 cycle during OWN with gnt=4'b0010 → next cycle gnt=0. With req=4'b0011 afterwards, the next grant is 4'b0001 (last reset to N-1).
- Non-owner eot pulses and owner req drop during OWN → no change to gnt.

Source files
------------

// File: rtl/rr_arbiter_tmo.sv
// Round-robin arbiter for one shared resource, with a per-grant hold watchdog
// that revokes a stuck owner and holds it back for one arbitration round.
module rr_arbiter_tmo #(
   parameter int N     = 4,
   parameter int TMO_W = 8,
   parameter int IDW   = $clog2(N)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     eot_i,
   input  logic [TMO_W-1:0] tmo_limit_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDW-1:0]   gnt_id_o,
   output logic             busy_o,
   output logic             tmo_pulse_o,
   output logic [IDW-1:0]   tmo_id_o
);

   // state | meaning
   // IDLE  | no owner; arbitrate over req & ~penalty, or clear a stale penalty
   // OWN   | grant visible; wait for owner eot or watchdog expiry
   typedef enum logic {IDLE, OWN} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [TMO_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N-1:0]     penalty_q, penalty_d;
   logic [TMO_W-1:0] limit_q, limit_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic             tmo_pulse_q, tmo_pulse_d;
   logic [IDW-1:0]   tmo_id_q, tmo_id_d;

   logic [N-1:0]     elig;
   logic             found;
   logic [IDW-1:0]   sel;
   logic [IDW-1:0]   cand;
   int unsigned      idx;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         last_q      <= IDW'(N - 1);
         hold_cnt_q  <= '0;
         penalty_q   <= '0;
         limit_q     <= '0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         tmo_pulse_q <= 1'b0;
         tmo_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         penalty_q   <= penalty_d;
         limit_q     <= limit_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         tmo_pulse_q <= tmo_pulse_d;
         tmo_id_q    <= tmo_id_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      penalty_d   = penalty_q;
      limit_d     = limit_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      tmo_pulse_d = 1'b0;
      tmo_id_d    = tmo_id_q;
      elig        = req_i & ~penalty_q;
      found       = 1'b0;
      sel         = '0;
      cand        = '0;
      idx         = 0;

      // Scan starts just after the previous owner and wraps modulo N.
      for (int i = 1; i <= N; i++) begin
         idx  = (int'(last_q) + i) % N;
         cand = IDW'(idx);
         if (!found && elig[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d      = '0;
               gnt_d[sel] = 1'b1;
               gnt_id_d   = sel;
               last_d     = sel;
               hold_cnt_d = '0;
               limit_d    = tmo_limit_i;
               penalty_d  = '0;
               state_d    = OWN;
            end else if (|penalty_q) begin
               penalty_d = '0;
            end
         end
         OWN: begin
            if (hold_cnt_q != {TMO_W{1'b1}})
               hold_cnt_d = hold_cnt_q + TMO_W'(1);
            if (eot_i[gnt_id_q]) begin
               gnt_d   = '0;
               state_d = IDLE;
            end else if ((limit_q != '0) && (hold_cnt_q == limit_q - TMO_W'(1))) begin
               gnt_d               = '0;
               state_d             = IDLE;
               tmo_pulse_d         = 1'b1;
               tmo_id_d            = gnt_id_q;
               penalty_d[gnt_id_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_o       = gnt_q;
   assign gnt_id_o    = gnt_id_q;
   assign busy_o      = |gnt_q;
   assign tmo_pulse_o = tmo_pulse_q;
   assign tmo_id_o    = tmo_id_q;

endmodule

// File: tb/tb_rr_arbiter_tmo.sv
// Directed bench for rr_arbiter_tmo (N=4, TMO_W=8): rotation, re-grant,
// watchdog revoke and penalty, eot/timeout tie, disabled watchdog, reset abort.
module tb_rr_arbiter_tmo;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] eot;
   logic [7:0] tmo_limit;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       tmo_pulse;
   logic [1:0] tmo_id;

   int checks   = 0;
   int failures = 0;
   int bad      = 0;

   rr_arbiter_tmo #(.N(4), .TMO_W(8)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .eot_i       (eot),
      .tmo_limit_i (tmo_limit),
      .gnt_o       (gnt),
      .gnt_id_o    (gnt_id),
      .busy_o      (busy),
      .tmo_pulse_o (tmo_pulse),
      .tmo_id_o    (tmo_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] oh;
      int         o;
      rst = 1'b1; req = 4'b0000; eot = 4'b0000; tmo_limit = 8'd0;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_gnt_id", 32'(gnt_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tmo_pulse", 32'(tmo_pulse), 32'h0);
      chk("rst_tmo_id", 32'(tmo_id), 32'h0);

      // Full rotation: owners 0,1,2,3,0, eot on 2nd grant cycle
      rst = 1'b0; req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         o  = k % 4;
         oh = 4'b0001 << o;
         chk("rot_gnt", 32'(gnt), 32'(oh));
         chk("rot_gnt_id", 32'(gnt_id), 32'(o));
         chk("rot_busy", 32'(busy), 32'h1);
         tick();
         chk("rot_gnt_c2", 32'(gnt), 32'(oh));
         eot = oh;
         tick();
         eot = 4'b0000;
         chk("rot_gap", 32'(gnt), 32'h0);
         chk("rot_gap_busy", 32'(busy), 32'h0);
         if (k == 4) req = 4'b0000;
         tick();
      end
      chk("rot_end", 32'(gnt), 32'h0);

      // Single requester 2, re-grant after eot with req still high
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0100;
      tick();
      chk("r2_gnt", 32'(gnt), 32'h4);
      eot = 4'b0100;
      tick();
      eot = 4'b0000;
      chk("r2_gap", 32'(gnt), 32'h0);
      tick();
      chk("r2_regnt", 32'(gnt), 32'h4);
      eot = 4'b0100; req = 4'b0000;
      tick();
      eot = 4'b0000;
      chk("r2_rel", 32'(gnt), 32'h0);

      // Watchdog limit 3 on requester 1; limit change mid-grant ignored
      tmo_limit = 8'd3; req = 4'b0010;
      tick();
      chk("t_gnt_c1", 32'(gnt), 32'h2);
      tmo_limit = 8'd10; req = 4'b1010;
      tick();
      chk("t_gnt_c2", 32'(gnt), 32'h2);
      tick();
      chk("t_gnt_c3", 32'(gnt), 32'h2);
      chk("t_no_pulse_c3", 32'(tmo_pulse), 32'h0);
      tick();
      chk("t_drop_gnt", 32'(gnt), 32'h0);
      chk("t_drop_pulse", 32'(tmo_pulse), 32'h1);
      chk("t_drop_id", 32'(tmo_id), 32'h1);
      tmo_limit = 8'd0;
      tick();
      chk("t_next_is_3", 32'(gnt), 32'h8);
      chk("t_pulse_1cyc", 32'(tmo_pulse), 32'h0);
      chk("t_id_hold", 32'(tmo_id), 32'h1);
      tmo_limit = 8'd3; req = 4'b0010; eot = 4'b1000;
      tick();
      eot = 4'b0000;
      chk("t_rel3", 32'(gnt), 32'h0);
      tick();
      chk("t2_gnt_c1", 32'(gnt), 32'h2);
      tick(); tick();
      chk("t2_gnt_c3", 32'(gnt), 32'h2);
      tick();
      chk("t2_drop_gnt", 32'(gnt), 32'h0);
      chk("t2_drop_pulse", 32'(tmo_pulse), 32'h1);
      tick();
      chk("t2_pen_clear", 32'(gnt), 32'h0);
      chk("t2_pulse_off", 32'(tmo_pulse), 32'h0);
      tick();
      chk("t2_regnt", 32'(gnt), 32'h2);

      // eot on 3rd cycle with limit 3: eot wins
      tick(); tick();
      eot = 4'b0010; req = 4'b0000;
      tick();
      eot = 4'b0000;
      chk("tie_gnt", 32'(gnt), 32'h0);
      chk("tie_no_pulse", 32'(tmo_pulse), 32'h0);
      tick();
      chk("tie_idle", 32'(gnt), 32'h0);

      // Watchdog disabled: 300-cycle hold, non-owner eot and req drop ignored
      tmo_limit = 8'd0; req = 4'b0100;
      tick();
      chk("nt_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      for (int i = 0; i < 300; i++) begin
         eot = (i % 7 == 0) ? 4'b1011 : 4'b0000;
         tick();
         if (gnt !== 4'b0100) bad++;
         if (tmo_pulse !== 1'b0) bad++;
      end
      eot = 4'b0000;
      chk("nt_hold_errors", 32'(bad), 32'h0);
      chk("nt_hold_sat", 32'(dut.hold_cnt_q), 32'hff);
      eot = 4'b0100;
      tick();
      eot = 4'b0000;
      chk("nt_rel", 32'(gnt), 32'h0);

      // Reset aborts grant of 1; last returns to N-1 so 0 wins next
      req = 4'b0010;
      tick();
      chk("ra_gnt", 32'(gnt), 32'h2);
      rst = 1'b1; req = 4'b0011;
      tick();
      chk("ra_gnt0", 32'(gnt), 32'h0);
      chk("ra_busy0", 32'(busy), 32'h0);
      chk("ra_tmo_id0", 32'(tmo_id), 32'h0);
      rst = 1'b0;
      tick();
      chk("ra_first_0", 32'(gnt), 32'h1);
      chk("ra_id_0", 32'(gnt_id), 32'h0);
      eot = 4'b0001; req = 4'b0000;
      tick();
      eot = 4'b0000;
      chk("ra_rel", 32'(gnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
